// File: rtl/hilo_unit.sv
// hilo_unit -- HI/LO multiply/divide unit.
//
// Runs 2*WIDTH-bit multiplies (MULT/MULTU), multiply-accumulate
// (MADD/MSUB) and restoring divides (DIV/DIVU) into a HI/LO register
// pair. HI/LO can also be loaded directly while the unit is idle.
//
// Ports:
//   Clk        rising-edge clock
//   Rst        asynchronous, active-low reset
//   Start      operation request; Op/A/B are sampled with it
//   Op         000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB
//   A, B       operands (multiplicand/multiplier or dividend/divisor)
//   WrHI, WrLO direct-write enables; WrData is the value written
//   HI, LO     registered results
//   Busy       an operation is in flight
//   Done       one-cycle pulse, HI/LO already show the result
//   DivByZero  one-cycle pulse with Done when a divide had B==0
//   dbg_state  current FSM state (0 IDLE, 1 MUL, 2 DIV)
//
// Handshake: a request is taken at a rising edge where Start==1,
// Busy==0 and Op is not 110/111. Nothing is queued; a Start that is
// not taken at that edge is simply lost. Done may coincide with a new
// accepted Start because Busy is already low in the Done cycle.
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             WrHI,
    input  logic             WrLO,
    input  logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Latched request
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Divider state: magnitudes, partial remainder, result signs
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvsr;
    logic             q_neg;
    logic             r_neg;
    logic             dz_q;
    logic [CW-1:0]    cnt;

    logic op_legal;
    logic is_div_op;
    logic accept;

    // FSM action strobes
    logic mul_wr;
    logic div_iter;
    logic div_wr;
    logic dz_wr;

    assign op_legal  = (Op != 3'b110) && (Op != 3'b111);
    assign is_div_op = (Op[2:1] == 2'b01);
    assign accept    = Start && (state == S_IDLE) && op_legal;

    assign Busy      = (state != S_IDLE);
    assign dbg_state = state;

    // ---------------- FSM ----------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mul_wr    = 1'b0;
        div_iter  = 1'b0;
        div_wr    = 1'b0;
        dz_wr     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = is_div_op ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                mul_wr    = 1'b1;
                state_nxt = S_IDLE;
            end
            S_DIV: begin
                // A zero divisor skips the iterations entirely.
                if (dz_q) begin
                    dz_wr     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cnt == CW'(WIDTH)) begin
                    div_wr    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    div_iter  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- Multiplier ----------------
    // One 2W x 2W multiplier serves signed and unsigned: operands are
    // sign- or zero-extended, and only the low 2W product bits are kept.
    logic             mul_sx;
    logic [2*WIDTH-1:0] ax;
    logic [2*WIDTH-1:0] bx;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mul_res;

    always_comb begin
        mul_sx = (op_q != OP_MULTU);
        ax     = {{WIDTH{mul_sx & a_q[WIDTH-1]}}, a_q};
        bx     = {{WIDTH{mul_sx & b_q[WIDTH-1]}}, b_q};
        prod   = ax * bx;
        case (op_q)
            OP_MADD: mul_res = {HI, LO} + prod;
            OP_MSUB: mul_res = {HI, LO} - prod;
            default: mul_res = prod;
        endcase
    end

    // ---------------- Divider ----------------
    // Restoring step: shift the next dividend bit into the remainder,
    // subtract the divisor if it fits, and shift the outcome into quo.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic             fits;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, dvsr};
        fits     = (rem_sh >= {1'b0, dvsr});
        rem_nxt  = fits ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nxt  = {quo[WIDTH-2:0], fits};
        // Most-negative / -1: magnitude quotient is 2^(W-1), which reads
        // back as the most-negative value when left unnegated (wrap).
        quo_fix  = q_neg ? (~quo + 1'b1) : quo;
        rem_fix  = r_neg ? (~rem + 1'b1) : rem;
    end

    // ---------------- Datapath registers ----------------
    logic a_neg;
    logic b_neg;

    assign a_neg = (Op == OP_DIV) & A[WIDTH-1];
    assign b_neg = (Op == OP_DIV) & B[WIDTH-1];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            HI        <= '0;
            LO        <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            quo       <= '0;
            rem       <= '0;
            dvsr      <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            dz_q      <= 1'b0;
            cnt       <= '0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;

            if (accept) begin
                op_q  <= Op;
                a_q   <= A;
                b_q   <= B;
                quo   <= a_neg ? (~A + 1'b1) : A;
                dvsr  <= b_neg ? (~B + 1'b1) : B;
                rem   <= '0;
                q_neg <= a_neg ^ b_neg;
                r_neg <= a_neg;
                dz_q  <= is_div_op && (B == '0);
                cnt   <= '0;
            end

            if (div_iter) begin
                rem <= rem_nxt;
                quo <= quo_nxt;
                cnt <= cnt + 1'b1;
            end

            if (mul_wr) begin
                {HI, LO} <= mul_res;
                Done     <= 1'b1;
            end

            if (div_wr) begin
                HI   <= rem_fix;
                LO   <= quo_fix;
                Done <= 1'b1;
            end

            if (dz_wr) begin
                Done      <= 1'b1;
                DivByZero <= 1'b1;
            end

            // Direct writes only land on a quiet idle edge.
            if ((state == S_IDLE) && !accept) begin
                if (WrHI) HI <= WrData;
                if (WrLO) LO <= WrData;
            end
        end
    end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO register width; legal values are even and at least 8.
REQ-002 Clk  in  1  rising-edge clock.
REQ-003 Rst  in  1  reset; asynchronous, active-low.
REQ-004 Start  in  1  operation request; qualified by Busy==0.
REQ-005 Op  in  3  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB; 110 and 111 reserved.
REQ-006 A, B  in  WIDTH  operands: multiplicand/multiplier, or dividend/divisor.
REQ-007 WrHI, WrLO  in  1  direct-write enables for HI and LO.
REQ-008 WrData  in  WIDTH  direct-write data.
REQ-009 HI, LO  out  WIDTH  registered results; readable at all times.
REQ-010 Busy  out  1  operation in flight.
REQ-011 Done  out  1  one-cycle completion pulse.
REQ-012 DivByZero  out  1  one-cycle pulse, coincident with Done, on a divide with B==0.

Function
REQ-013 The unit SHALL have states IDLE, MUL and DIV; Busy SHALL be 1 exactly when the state is not IDLE.
REQ-014 Start with Busy==0 and a non-reserved Op SHALL be accepted at that rising edge (E0); A, B and Op SHALL be latched at E0.
REQ-015 Start while Busy==1, or Start with a reserved Op, SHALL be ignored: no state change, no Done.
REQ-016 Operation latency SHALL be defined as follows.
- MULT, MULTU, MADD, MSUB: E0 moves to MUL; E1 writes HI/LO and returns to IDLE.
- DIV, DIVU with B!=0: E0 moves to DIV; E1..E(WIDTH) perform one restoring quotient-bit iteration each; E(WIDTH+1) writes HI/LO and returns to IDLE.
- Busy SHALL therefore be high for 1 cycle on multiplies and WIDTH+1 cycles on divides.
REQ-017 Done SHALL be high for the single cycle after the HI/LO write edge, while HI/LO already show the new values.
REQ-018 MULT/MULTU SHALL set {HI,LO} to the full 2*WIDTH-bit product, signed or unsigned respectively.
REQ-019 MADD/MSUB SHALL set {HI,LO} = {HI,LO} +/- signed(A)*signed(B), modulo 2^(2*WIDTH).
- The {HI,LO} value used is the one present at E1.
REQ-020 DIVU SHALL set LO = quotient and HI = remainder, both unsigned.
REQ-021 DIV SHALL divide magnitudes, then apply signs.
- Quotient is negative iff sign(A)!=sign(B); it truncates toward zero.
- Remainder takes the sign of A.
REQ-022 DIV with A = most-negative value and B = -1 SHALL produce LO = most-negative value (wrap) and HI = 0.
REQ-023 A divide with B==0 SHALL go from E0 to IDLE at E1, pulse Done and DivByZero after E1, and leave HI/LO unchanged.
REQ-024 WrHI/WrLO SHALL load WrData into HI/LO at the edge only when Busy==0 and no Start is accepted at that edge.
- When both are asserted, both registers are loaded.
- Otherwise the write is dropped, with no error indication.
REQ-025 HI/LO SHALL hold their previous values throughout Busy; intermediate divide/multiply state SHALL NOT be visible on HI/LO.
REQ-026 Done SHALL NOT assert for direct writes or for ignored requests.
REQ-027 A new Start SHALL be acceptable in the cycle where Done is high, since Busy==0 in that cycle.

Reset
REQ-028 Rst low SHALL immediately force HI=0, LO=0, Busy=0, Done=0, DivByZero=0 and state IDLE, independent of Clk.
REQ-029 Reset asserted mid-operation SHALL abort it: no HI/LO write and no Done after release.
REQ-030 After Rst deasserts, the first edge SHALL be able to accept Start.

Verification (WIDTH=32)
REQ-031 MULT A=0xFFFFFFFD (-3), B=7 -> one cycle after accept: HI=0xFFFFFFFF, LO=0xFFFFFFEB; Done pulses once; Busy high 1 cycle.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> Busy high 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF, Done pulses once.
REQ-033 DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0; then DIVU with B=0 -> HI/LO unchanged, Done and DivByZero pulse together after 1 cycle.
REQ-034 WrHI=0, WrLO=0xFFFFFFFF, then MADD A=1, B=1 -> HI=0x00000001, LO=0x00000000.
REQ-035 During a DIVU, apply Start (MULT) and WrLO=0x1234 -> both ignored; the divide result is written; LO!=0x1234.
REQ-036 Assert Rst at cycle 10 of a DIVU -> HI=LO=0 and Busy=0 immediately; no Done after release; a next MULTU 5*6 -> LO=30, HI=0.
